// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I data-memory bridge.
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Load value returned to the core when an access fails
    localparam logic [31:0] FAULT_LOAD = 32'h0000_0000;

    // Write-enable lane masks (half and word built from the byte lane)
    localparam logic [3:0] WE_BYTE = 4'b0001;
    localparam logic [3:0] WE_HALF = WE_BYTE | (WE_BYTE << 1);
    localparam logic [3:0] WE_WORD = WE_HALF | (WE_HALF << 2);

    // Alignment rule: store wins over load; byte stores are always aligned
    function automatic logic is_misaligned(input logic rd, input logic [3:0] we,
                                           input logic [1:0] a);
        logic mis;
        mis = 1'b0;
        if (|we) begin
            if (we == WE_WORD)
                mis = (a != 2'b00);
            else if (we == WE_HALF || we == (WE_HALF << 2))
                mis = a[0];
        end else begin
            mis = rd && (a != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/riscv_bus_timeout.sv
// Wait-cycle counter for an outstanding bus request; expires on the
// TIMEOUT-th cycle without an ack.
module riscv_bus_timeout #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CW      = 8
) (
    input  logic clk,
    input  logic clrn,
    input  logic i_start,
    input  logic i_run,
    output logic o_expire
);

    logic [CW-1:0] r_count;

    assign o_expire = i_run && (r_count == CW'(TIMEOUT - 1));

    // Count non-acked request cycles; restart on every new transaction
    always_ff @(posedge clk) begin
        if (clrn)
            r_count <= '0;
        else if (i_start)
            r_count <= '0;
        else if (i_run && !o_expire)
            r_count <= r_count + CW'(1);
    end

endmodule

// File: rtl/riscv_dmem_bridge.sv
// Core data port to valid/ack bus bridge with timeout and fault reporting.
// Optional build macro RISCV_DMEM_MISALIGN_EN adds an alignment check in IDLE
// and a 'misalign' pulse output.
module riscv_dmem_bridge
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CW      = 8
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] m_addr,
    input  logic [31:0] d_t_mem,
    input  logic [3:0]  write,
    input  logic        read,
    output logic [31:0] d_f_mem,
    output logic        stall,
    output logic        fault,
    output logic        fault_sticky,
`ifdef RISCV_DMEM_MISALIGN_EN
    output logic        misalign,
`endif
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata
);

    state_t      r_state, w_state_nxt;
    logic        r_bus_req, r_bus_we, r_fault, r_fault_sticky;
    logic [31:0] r_bus_addr, r_bus_wdata, r_d_f_mem;
    logic [3:0]  r_bus_be;

    logic        w_bus_req_nxt, w_bus_we_nxt, w_fault_nxt, w_stall;
    logic [31:0] w_bus_addr_nxt, w_bus_wdata_nxt, w_d_f_mem_nxt;
    logic [3:0]  w_bus_be_nxt;
    logic        w_is_store, w_is_req, w_misalign, w_start, w_run, w_expire;

    assign w_is_store = |write;
    assign w_is_req   = w_is_store | read;

`ifdef RISCV_DMEM_MISALIGN_EN
    logic r_misalign;
    assign w_misalign = is_misaligned(read, write, m_addr[1:0]);
    assign misalign   = r_misalign;

    // Misalign pulse coincides with the fault pulse in DONE
    always_ff @(posedge clk) begin
        if (clrn)
            r_misalign <= 1'b0;
        else
            r_misalign <= (r_state == ST_IDLE) && w_is_req && w_misalign;
    end
`else
    logic w_unused_addr;
    assign w_misalign    = 1'b0;
    assign w_unused_addr = ^m_addr[1:0];
`endif

    assign w_run = (r_state == ST_REQ) && !bus_ack;

    riscv_bus_timeout #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_timeout (
        .clk      (clk),
        .clrn     (clrn),
        .i_start  (w_start),
        .i_run    (w_run),
        .o_expire (w_expire)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (clrn) begin
            r_state        <= ST_IDLE;
            r_bus_req      <= 1'b0;
            r_bus_we       <= 1'b0;
            r_bus_addr     <= '0;
            r_bus_wdata    <= '0;
            r_bus_be       <= '0;
            r_d_f_mem      <= '0;
            r_fault        <= 1'b0;
            r_fault_sticky <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_bus_req      <= w_bus_req_nxt;
            r_bus_we       <= w_bus_we_nxt;
            r_bus_addr     <= w_bus_addr_nxt;
            r_bus_wdata    <= w_bus_wdata_nxt;
            r_bus_be       <= w_bus_be_nxt;
            r_d_f_mem      <= w_d_f_mem_nxt;
            r_fault        <= w_fault_nxt;
            r_fault_sticky <= r_fault_sticky | w_fault_nxt;
        end
    end

    // Next-state: IDLE -> REQ (or straight to DONE on misalign) -> DONE -> IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_is_req) w_state_nxt = w_misalign ? ST_DONE : ST_REQ;
            ST_REQ:  if (bus_ack || w_expire) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output next-values; any fault forces the load data to FAULT_LOAD
    always_comb begin
        w_bus_req_nxt   = r_bus_req;
        w_bus_we_nxt    = r_bus_we;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_wdata_nxt = r_bus_wdata;
        w_bus_be_nxt    = r_bus_be;
        w_d_f_mem_nxt   = r_d_f_mem;
        w_fault_nxt     = 1'b0;
        w_start         = 1'b0;
        w_stall         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall = w_is_req;
                if (w_is_req) begin
                    if (w_misalign) begin
                        w_fault_nxt   = 1'b1;
                        w_d_f_mem_nxt = FAULT_LOAD;
                    end else begin
                        w_start         = 1'b1;
                        w_bus_req_nxt   = 1'b1;
                        w_bus_we_nxt    = w_is_store;
                        w_bus_addr_nxt  = {m_addr[31:2], 2'b00};
                        w_bus_wdata_nxt = d_t_mem;
                        w_bus_be_nxt    = w_is_store ? write : WE_WORD;
                    end
                end
            end
            ST_REQ: begin
                w_stall = 1'b1;
                if (bus_ack) begin
                    w_bus_req_nxt = 1'b0;
                    if (bus_err) begin
                        w_fault_nxt   = 1'b1;
                        w_d_f_mem_nxt = FAULT_LOAD;
                    end else if (!r_bus_we) begin
                        w_d_f_mem_nxt = bus_rdata;
                    end
                end else if (w_expire) begin
                    w_bus_req_nxt = 1'b0;
                    w_fault_nxt   = 1'b1;
                    w_d_f_mem_nxt = FAULT_LOAD;
                end
            end
            default: ;
        endcase
    end

    assign stall        = w_stall;
    assign bus_req      = r_bus_req;
    assign bus_we       = r_bus_we;
    assign bus_addr     = r_bus_addr;
    assign bus_wdata    = r_bus_wdata;
    assign bus_be       = r_bus_be;
    assign d_f_mem      = r_d_f_mem;
    assign fault        = r_fault;
    assign fault_sticky = r_fault_sticky;

endmodule

// File: tb/tb_riscv_dmem_bridge.sv
// Self-checking bench for riscv_dmem_bridge: directed cases plus random accesses
// against a transaction-level model of the bridge.
module tb_riscv_dmem_bridge;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] m_addr, d_t_mem, d_f_mem;
    logic [3:0]  write;
    logic        read;
    logic        stall, fault, fault_sticky;
    logic        bus_req, bus_we, bus_ack, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
`ifdef RISCV_DMEM_MISALIGN_EN
    logic        misalign;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    // Model state carried across accesses
    logic [31:0] exp_dout;
    logic        exp_sticky;

    always #5 clk = ~clk;

    riscv_dmem_bridge #(.TIMEOUT(TMO), .CW(8)) dut (
        .clk          (clk),
        .clrn         (clrn),
        .m_addr       (m_addr),
        .d_t_mem      (d_t_mem),
        .write        (write),
        .read         (read),
        .d_f_mem      (d_f_mem),
        .stall        (stall),
        .fault        (fault),
        .fault_sticky (fault_sticky),
`ifdef RISCV_DMEM_MISALIGN_EN
        .misalign     (misalign),
`endif
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_be       (bus_be),
        .bus_ack      (bus_ack),
        .bus_err      (bus_err),
        .bus_rdata    (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One core access with a scripted slave: ack after wait_n wait cycles,
    // or never (ack_en=0). Entered and left just after a falling edge.
    task automatic access(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int wait_n, input logic ack_en,
                          input logic err, input logic [31:0] rdat);
        logic        st, mis, flt, stable, done;
        int          cyc, reqc, exp_reqc;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        st  = |wr;
        mis = 1'b0;
`ifdef RISCV_DMEM_MISALIGN_EN
        if (st) mis = (wr == 4'hF && addr[1:0] != 2'b00) ||
                      ((wr == 4'h3 || wr == 4'hC) && addr[0]);
        else    mis = (addr[1:0] != 2'b00);
`endif
        exp_addr = addr & 32'hFFFF_FFFC;
        exp_be   = st ? wr : 4'hF;
        flt      = mis || !ack_en || err;
        exp_reqc = mis ? 0 : (ack_en ? wait_n + 1 : TMO);
        if (flt)      exp_dout = 32'h0;
        else if (!st) exp_dout = rdat;
        exp_sticky = exp_sticky | flt;

        read = rd; write = wr; m_addr = addr; d_t_mem = wd;
        bus_rdata = rdat; bus_err = err; bus_ack = 1'b0;
        cyc = 0; reqc = 0; stable = 1'b1; done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            #1;
            if (!stall) begin
                done = 1'b1;
            end else begin
                cyc++;
                if (bus_req) begin
                    reqc++;
                    if (bus_addr !== exp_addr || bus_be !== exp_be || bus_we !== st ||
                        (st && bus_wdata !== wd))
                        stable = 1'b0;
                    bus_ack = ack_en && (reqc == wait_n + 1);
                end else begin
                    bus_ack = 1'b0;
                end
                @(negedge clk);
            end
        end
        bus_ack = 1'b0;
        check("reach_done", 32'(done), 32'd1);
        check("stall_cycles", 32'(cyc), 32'(1 + exp_reqc));
        check("req_cycles", 32'(reqc), 32'(exp_reqc));
        if (!mis) check("bus_fields", 32'(stable), 32'd1);
        check("req_dropped", 32'(bus_req), 32'd0);
        check("d_f_mem", d_f_mem, exp_dout);
        check("fault", 32'(fault), 32'(flt));
        check("fault_sticky", 32'(fault_sticky), 32'(exp_sticky));
`ifdef RISCV_DMEM_MISALIGN_EN
        check("misalign", 32'(misalign), 32'(mis));
`endif
        read = 1'b0; write = 4'h0;
        @(negedge clk); #1;
        check("fault_pulse_end", 32'(fault), 32'd0);
        check("idle_no_stall", 32'(stall), 32'd0);
    endtask

    initial begin
        logic [3:0] wr_tab [8];
        logic [3:0] wr;
        logic       rd;
        wr_tab = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

        // Reset
        clrn = 1'b1; read = 1'b0; write = 4'h0; m_addr = '0; d_t_mem = '0;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
        exp_dout = 32'h0; exp_sticky = 1'b0;
        repeat (2) @(negedge clk);
        clrn = 1'b0;
        #1;
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_bus_be", 32'(bus_be), 32'h0);
        check("rst_d_f_mem", d_f_mem, 32'h0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_sticky", 32'(fault_sticky), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);

        // Directed: zero-wait load, waited half store, timeout, bus error, read+write
        access(1'b1, 4'h0, 32'h0000_0104, 32'h0, 0, 1'b1, 1'b0, 32'hCAFE_F00D);
        access(1'b0, 4'h3, 32'h0000_0200, 32'h1234_5678, 3, 1'b1, 1'b0, 32'hDEAD_0000);
        access(1'b1, 4'h0, 32'h0000_0300, 32'h0, 0, 1'b0, 1'b0, 32'h5555_AAAA);
        access(1'b1, 4'h0, 32'h0000_0400, 32'h0, 1, 1'b1, 1'b1, 32'h7777_7777);
        access(1'b1, 4'h0, 32'h0000_0404, 32'h0, 0, 1'b1, 1'b0, 32'h0BAD_F00D);
        access(1'b1, 4'hF, 32'h0000_0500, 32'hA5A5_5A5A, 2, 1'b1, 1'b0, 32'h1111_2222);
`ifdef RISCV_DMEM_MISALIGN_EN
        access(1'b1, 4'h0, 32'h0000_0102, 32'h0, 0, 1'b1, 1'b0, 32'h3333_4444);
`endif

        // Reset in REQ: clrn during the 2nd wait cycle, late ack ignored
        read = 1'b1; m_addr = 32'h0000_0600; bus_ack = 1'b0; bus_err = 1'b0;
        @(negedge clk); @(negedge clk);
        clrn = 1'b1; read = 1'b0;
        @(negedge clk); #1;
        clrn = 1'b0;
        exp_dout = 32'h0; exp_sticky = 1'b0;
        check("rreq_bus_req", 32'(bus_req), 32'd0);
        check("rreq_stall", 32'(stall), 32'd0);
        check("rreq_sticky", 32'(fault_sticky), 32'd0);
        check("rreq_d_f_mem", d_f_mem, 32'h0);
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_0000;
        @(negedge clk); #1;
        bus_ack = 1'b0;
        check("late_ack_req", 32'(bus_req), 32'd0);
        check("late_ack_fault", 32'(fault), 32'd0);
        check("late_ack_dout", d_f_mem, 32'h0);

        // Random accesses
        for (int i = 0; i < 40; i++) begin
            wr = wr_tab[$urandom_range(0, 7)];
            rd = (wr == 4'h0) ? 1'b1 : 1'($urandom_range(0, 1));
            access(rd, wr, $urandom, $urandom, int'($urandom_range(0, 4)),
                   ($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/riscv_dmem_bridge.md
Name: riscv_dmem_bridge

Overview:
- Sits directly downstream of the single-cycle RV32I core's data port.
- Consumes the core's m_addr, d_t_mem, write[3:0] and read, and turns each access into one valid/ack bus transaction.
- Returns load data on d_f_mem and holds the core with a stall output until the transaction completes.
- Adds a bus timeout and a sticky fault flag so a dead slave cannot hang the core.

Parameters:
- TIMEOUT, 16: max REQ-state cycles waiting for bus_ack before abort; legal range 2..255.
- CW, 8: timeout counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  single clock, rising edge
- clrn  in  1  synchronous, active-high reset; 1 resets all state at the next rising clk edge
- m_addr  in  32  core data address
- d_t_mem  in  32  core store data
- write  in  4  core byte write enables; any bit set = store
- read  in  1  core load request
- d_f_mem  out  32  load data to core
- stall  out  1  hold core PC/regfile while 1
- fault  out  1  one-cycle pulse in DONE when the access failed
- fault_sticky  out  1  set on any fault; cleared only by clrn
- bus_req  out  1  transaction valid
- bus_we  out  1  1 = write
- bus_addr  out  32  word address {addr[31:2],2'b00}
- bus_wdata  out  32  write data
- bus_be  out  4  byte enables (4'b1111 for reads)
- bus_ack  in  1  slave completion; sampled only while bus_req=1
- bus_err  in  1  slave error; valid with bus_ack
- bus_rdata  in  32  read data, valid with bus_ack

Behaviour:
- Reset values: state=IDLE; bus_req=0; bus_we=0; bus_addr, bus_wdata, d_f_mem=0; bus_be=0; fault=0; fault_sticky=0; counter=0.
- stall is combinational: 1 in IDLE when (read | |write), 1 in REQ, 0 in DONE.
- IDLE:
  - A request is present when read=1 or write!=0.
  - If both are present, the store wins and read is ignored.
  - On a request: latch addr, wdata, be, we into the bus registers; set bus_req=1; clear the counter; go to REQ.
  - With no request, stay in IDLE.
- REQ:
  - bus_req held at 1; address, data and be held stable.
  - bus_ack=1 with bus_err=0: bus_req=0 at the edge; for reads, capture bus_rdata into d_f_mem; go to DONE.
  - bus_ack=1 with bus_err=1: as above, but load data = 32'h0000_0000 and fault is raised in DONE.
  - bus_ack=0: counter increments. When the counter reaches TIMEOUT-1 without an ack, drop bus_req, set d_f_mem=0, flag a fault, go to DONE.
- DONE:
  - stall=0 so the core commits this instruction.
  - d_f_mem is stable for the whole cycle.
  - fault pulses here if flagged.
  - Always go to IDLE; the next instruction's request is seen in IDLE.
- Latency: ack in the first REQ cycle gives 3 cycles per access (IDLE, REQ, DONE), 2 of them stalled. Each extra wait cycle adds 1.
- d_f_mem holds its last value between loads; stores do not change it.
- A late bus_ack while in IDLE or DONE is ignored.
- Reset mid-transaction: the next edge forces IDLE and bus_req=0, and fault_sticky clears.
- The slave must tolerate bus_req dropping without an ack (timeout or reset).
- Sub-word loads return the raw aligned word; the core does byte select and sign extension.

Optional Feature:
- Macro: RISCV_DMEM_MISALIGN_EN.
- Defined: IDLE checks alignment before issuing.
  - Misaligned means write=4'b1111 or read with m_addr[1:0]!=0, or write in {4'b0011, 4'b1100} with m_addr[0]=1.
  - A misaligned access issues no bus transaction, goes IDLE to DONE directly (stall for 1 cycle), and raises fault with d_f_mem=0.
  - An extra output misalign (1 bit) pulses alongside fault.
- Undefined: no check; m_addr[1:0] is dropped; the misalign port is absent.

Decomposition:
- Shared package riscv_pkg holds:
  - the state encoding typedef (IDLE=2'd0, REQ=2'd1, DONE=2'd2);
  - the fault-load constant 32'h0;
  - the write-enable masks for byte, half and word.
- Natural sub-module: riscv_bus_timeout, the counter with start/clear/expire outputs, parameterised by TIMEOUT and CW.

Test Plan:
- Load, zero wait: read=1, m_addr=32'h0000_0104; slave acks in the 1st REQ cycle with bus_rdata=32'hCAFE_F00D -> bus_addr=0x104, bus_be=4'hF, stall high for 2 cycles, d_f_mem=0xCAFEF00D in DONE, fault=0.
- Store with wait states: write=4'b0011, m_addr=0x200, d_t_mem=0x1234_5678; ack after 3 wait cycles -> bus_we=1, bus_be=4'b0011, bus_wdata stable all REQ cycles, stall for 5 cycles.
- Timeout: TIMEOUT=16, slave never acks -> bus_req drops after 16 REQ cycles, fault pulses once, fault_sticky=1, d_f_mem=0.
- Bus error: ack with bus_err=1 on a load -> d_f_mem=0, fault=1 in DONE, fault_sticky stays 1 across later good accesses.
- Read and write together: read=1, write=4'hF -> a single write transaction, bus_we=1.
- Reset in REQ: assert clrn during the 2nd wait cycle -> bus_req=0 and state IDLE next edge; a later ack is ignored; fault_sticky=0.
- With RISCV_DMEM_MISALIGN_EN: read at 0x102 -> no bus_req, stall for 1 cycle, fault=1, misalign=1.
